// File: rtl/core_driver_if.sv
// CORE instruction/result port bundle between the program driver and CORE.
`timescale 1ns/1ps
interface core_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [31:0]           o_instr;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data1;
  logic                  i_valid1;

  modport master (output o_instr, o_valid, input i_ready, i_data1, i_valid1);
  modport slave  (input o_instr, o_valid, output i_ready, i_data1, i_valid1);
endinterface

// File: rtl/core_driver.sv
// Replays a host-loaded program into CORE and captures CORE results in a FIFO;
// issue is credit-limited so every in-flight result has a guaranteed FIFO slot.
`timescale 1ns/1ps
module core_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int PROG_DEPTH = 16,
  parameter int RES_DEPTH  = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [31:0]           i_prog_instr,
  input  logic                  i_prog_we,
  output logic                  o_prog_full,
  input  logic                  i_clear,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  core_driver_if.master         core,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic                  o_err,
  output logic [1:0]            o_state
);
  localparam int PAW = $clog2(PROG_DEPTH);
  localparam int PCW = $clog2(PROG_DEPTH + 1);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int RCW = $clog2(RES_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [31:0]           prog_mem [PROG_DEPTH];
  logic [PCW-1:0]        prog_count;
  logic [PAW-1:0]        rd_ptr;
  logic [RCW-1:0]        outstanding, outstanding_nxt;
  logic [RCW-1:0]        res_count, res_count_nxt;
  logic [DATA_WIDTH-1:0] res_mem [RES_DEPTH];
  logic [RAW-1:0]        res_wr_ptr, res_rd_ptr;
  logic                  err_q;

  logic idle, run, prog_wr, credit_ok, issue, last_word;
  logic has_out, res_pop, res_space, res_push, res_drop, res_retire;

  assign idle        = (state == S_IDLE);
  assign run         = (state == S_RUN);
  assign o_prog_full = (prog_count == PCW'(PROG_DEPTH));
  assign prog_wr     = idle && i_prog_we && !o_prog_full && !i_clear;

  // Handshake: a word transfers on a cycle where o_valid && i_ready. o_valid only
  // depends on FIFO credits, which can only grow via host pops, so once raised it
  // stays high with o_instr stable until the transfer happens.
  assign credit_ok  = ((RCW+1)'(res_count) + (RCW+1)'(outstanding)) < (RCW+1)'(RES_DEPTH);
  assign issue      = run && credit_ok && core.i_ready;
  assign last_word  = (PCW'(rd_ptr) == prog_count - PCW'(1));

  assign has_out    = (outstanding != '0);
  assign res_pop    = o_res_valid && i_res_ready;
  assign res_space  = (res_count != RCW'(RES_DEPTH)) || res_pop;
  assign res_push   = core.i_valid1 && has_out && res_space;
  assign res_drop   = core.i_valid1 && !res_push;
  assign res_retire = core.i_valid1 && has_out;

  assign outstanding_nxt = outstanding + RCW'(issue) - RCW'(res_retire);
  assign res_count_nxt   = res_count + RCW'(res_push) - RCW'(res_pop);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start && !i_clear) state_nxt = (prog_count != '0) ? S_RUN : S_DONE;
      S_RUN:   if (issue && last_word) state_nxt = S_DRAIN;
      S_DRAIN: if (outstanding_nxt == '0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state       <= S_IDLE;
      prog_count  <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      res_count   <= '0;
      res_wr_ptr  <= '0;
      res_rd_ptr  <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      res_count   <= res_count_nxt;
      if (idle && i_clear)  prog_count <= '0;
      else if (prog_wr)     prog_count <= prog_count + PCW'(1);
      if (issue)                 rd_ptr <= rd_ptr + PAW'(1);
      else if (state == S_DONE)  rd_ptr <= '0;
      if (res_push) res_wr_ptr <= res_wr_ptr + RAW'(1);
      if (res_pop)  res_rd_ptr <= res_rd_ptr + RAW'(1);
      if (res_drop) err_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above.
  always_ff @(posedge i_CLK) begin
    if (prog_wr)  prog_mem[prog_count[PAW-1:0]] <= i_prog_instr;
    if (res_push) res_mem[res_wr_ptr] <= core.i_data1;
  end

  assign core.o_instr = run ? prog_mem[rd_ptr] : '0;
  assign core.o_valid = run && credit_ok;
  assign o_res_valid  = (res_count != '0);
  assign o_res_data   = o_res_valid ? res_mem[res_rd_ptr] : '0;
  assign o_busy       = !idle;
  assign o_done       = (state == S_DONE);
  assign o_err        = err_q;
  assign o_state      = state;
endmodule

// File: tb/tb_core_driver.sv
// Directed bench for core_driver: CORE echo model, expected-queue scoreboard, summary.
`timescale 1ns/1ps
module tb_core_driver;
  localparam int DW = 8;
  localparam int PD = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] prog_instr;
  logic        prog_we, clear, start, res_ready, ready, echo_en, inj_v, mdl_v;
  logic [7:0]  inj_d, mdl_d;
  logic        prog_full, busy, done, res_valid, err;
  logic [7:0]  res_data;
  logic [1:0]  state;

  core_driver_if #(.DATA_WIDTH(DW)) cif();
  assign cif.i_ready  = ready;
  assign cif.i_valid1 = mdl_v | inj_v;
  assign cif.i_data1  = inj_v ? inj_d : mdl_d;

  core_driver #(.DATA_WIDTH(DW), .PROG_DEPTH(PD), .RES_DEPTH(16)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_prog_instr(prog_instr), .i_prog_we(prog_we), .o_prog_full(prog_full),
    .i_clear(clear), .i_start(start), .o_busy(busy), .o_done(done),
    .core(cif),
    .o_res_data(res_data), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_err(err), .o_state(state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_instr_q[$];
  logic [7:0]  exp_res_q[$];
  logic [31:0] mdl_prog [PD];
  int mdl_cnt = 0;
  int n_cmp = 0, n_err = 0, iss_cnt = 0, res_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CORE model: echoes the low byte of each accepted instruction two cycles later.
  initial begin : core_echo
    logic hs, v0;
    logic [7:0] hd, d0;
    mdl_v = 1'b0; mdl_d = '0; v0 = 1'b0; d0 = '0;
    forever begin
      @(negedge clk);
      hs = cif.o_valid && ready;
      hd = cif.o_instr[7:0];
      @(posedge clk); #1;
      mdl_v = v0 && echo_en;
      mdl_d = d0;
      v0 = hs && echo_en;
      d0 = hd;
    end
  end

  // Monitors: compare every accepted instruction and every popped result.
  always @(negedge clk) begin
    if (!rst && cif.o_valid && ready) begin
      iss_cnt++;
      n_cmp++;
      if (exp_instr_q.size() == 0) begin
        n_err++;
        $display("FAIL instr_unexpected: got %0h expected none", cif.o_instr);
      end else begin
        logic [31:0] e;
        e = exp_instr_q.pop_front();
        if (cif.o_instr !== e) begin
          n_err++;
          $display("FAIL instr_order: got %0h expected %0h", cif.o_instr, e);
        end
      end
    end
    if (!rst && cif.i_valid1) res_seen++;
    if (!rst && res_valid && res_ready) begin
      n_cmp++;
      if (exp_res_q.size() == 0) begin
        n_err++;
        $display("FAIL res_unexpected: got %0h expected none", res_data);
      end else begin
        logic [7:0] e;
        e = exp_res_q.pop_front();
        if (res_data !== e) begin
          n_err++;
          $display("FAIL res_order: got %0h expected %0h", res_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    prog_instr = w; prog_we = 1'b1; tick(); prog_we = 1'b0;
    if (mdl_cnt < PD) begin
      mdl_prog[mdl_cnt] = w;
      mdl_cnt++;
    end
  endtask

  task automatic clear_prog();
    clear = 1'b1; tick(); clear = 1'b0; mdl_cnt = 0;
  endtask

  task automatic start_run();
    for (int i = 0; i < mdl_cnt; i++) begin
      exp_instr_q.push_back(mdl_prog[i]);
      exp_res_q.push_back(mdl_prog[i][7:0]);
    end
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int b = 0;
    while (!done && b < budget) begin tick(); b++; end
    check({name, "_done"}, done, 1'b1);
    tick();
    check({name, "_done_pulse"}, done, 1'b0);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      int b = 0;
      while (!res_valid && b < 50) begin tick(); b++; end
      if (!res_valid) check("pop_wait", res_valid, 1'b1);
      else begin res_ready = 1'b1; tick(); res_ready = 1'b0; end
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int base;
    rst = 1'b1; prog_instr = '0; prog_we = 1'b0; clear = 1'b0; start = 1'b0;
    res_ready = 1'b0; ready = 1'b1; echo_en = 1'b1; inj_v = 1'b0; inj_d = '0;
    #1;
    check("rst_valid", cif.o_valid, 1'b0);
    check("rst_instr", cif.o_instr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: three-word program, results kept in order
    load_word(32'h11); load_word(32'h22); load_word(32'h33);
    base = res_seen;
    start_run();
    while (!done && res_seen - base < 3 + 20) begin
      if (done) break;
      tick();
      if (res_seen - base > 3) break;
    end
    check("t1_done", done, 1'b1);
    check("t1_results_before_done", res_seen - base, 3);
    check("t1_fifo_nonempty", res_valid, 1'b1);
    tick();
    check("t1_done_pulse", done, 1'b0);
    pop_n(3);
    check("t1_fifo_empty", res_valid, 1'b0);

    // 2: backpressure holds o_valid/o_instr stable
    clear_prog();
    load_word(32'h44); load_word(32'h55);
    ready = 1'b0;
    base = iss_cnt;
    start_run();
    for (int i = 0; i < 5; i++) begin
      check("t2_valid_held", cif.o_valid, 1'b1);
      check("t2_instr_held", cif.o_instr, 32'h44);
      tick();
    end
    check("t2_no_advance", iss_cnt - base, 0);
    check("t2_state_run", state, 2'd1);
    ready = 1'b1;
    wait_done("t2", 50);
    pop_n(2);

    // 3: credit stall; 4 results already stored, so a 16-word run stalls at 12
    clear_prog();
    for (int i = 0; i < 4; i++) load_word(32'hA0 + i);
    start_run();
    wait_done("t3a", 50);
    clear_prog();
    for (int i = 0; i < 16; i++) load_word(32'hC0 + i);
    base = iss_cnt;
    start_run();
    repeat (40) tick();
    check("t3_issued_at_stall", iss_cnt - base, 12);
    check("t3_valid_stalled", cif.o_valid, 1'b0);
    check("t3_busy", busy, 1'b1);
    pop_n(4);
    wait_done("t3", 100);
    check("t3_issued_total", iss_cnt - base, 16);
    pop_n(16);
    check("t3_fifo_empty", res_valid, 1'b0);
    check("t3_err_clear", err, 1'b0);

    // 4: unexpected result in IDLE sets sticky error, FIFO untouched
    inj_d = 8'hAB; inj_v = 1'b1; tick(); inj_v = 1'b0;
    check("t4_err_set", err, 1'b1);
    check("t4_fifo_unchanged", res_valid, 1'b0);
    repeat (3) tick();
    check("t4_err_sticky", err, 1'b1);

    // 5: program full at 16 words, 17th ignored; empty program goes straight to DONE
    clear_prog();
    for (int i = 0; i < 17; i++) begin
      load_word(32'h100 + i);
      if (i == 14) check("t5_not_full_15", prog_full, 1'b0);
      if (i == 15) check("t5_full_16", prog_full, 1'b1);
    end
    check("t5_full_17", prog_full, 1'b1);
    res_ready = 1'b1;
    start_run();
    wait_done("t5", 100);
    repeat (3) tick();
    res_ready = 1'b0;
    check("t5_fifo_drained", res_valid, 1'b0);
    check("t5_instr_q_empty", exp_instr_q.size(), 0);
    check("t5_res_q_empty", exp_res_q.size(), 0);
    clear_prog();
    check("t5_cleared", prog_full, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_empty_done", done, 1'b1);
    check("t5_empty_no_valid", cif.o_valid, 1'b0);
    tick();
    check("t5_empty_done_pulse", done, 1'b0);

    // 6: reset in the middle of a run with two results outstanding
    for (int i = 0; i < 4; i++) load_word(32'hE0 + i);
    base = iss_cnt;
    start_run();
    for (int b = 0; b < 50 && iss_cnt - base < 2; b++) tick();
    rst = 1'b1; echo_en = 1'b0;
    #1;
    check("t6_valid", cif.o_valid, 1'b0);
    check("t6_instr", cif.o_instr, 32'h0);
    check("t6_busy", busy, 1'b0);
    check("t6_err", err, 1'b0);
    check("t6_res_valid", res_valid, 1'b0);
    exp_instr_q.delete();
    exp_res_q.delete();
    mdl_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("t6_prog_empty", prog_full, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_count_zero_done", done, 1'b1);
    repeat (3) tick();
    check("t6_err_quiet", err, 1'b0);
    check("t6_fifo_empty", res_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
